// File: rtl/cursor_motion.sv
// rtl/cursor_motion.sv - terminal byte interpreter producing cursor moves, character writes and scroll requests
module cursor_motion #(
  parameter int ROW_BITS = 5,
  parameter int COL_BITS = 7,
  parameter int ROWS     = 24,
  parameter int COLS     = 80
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          data,
  input  logic                valid,
  output logic                ready,
  input  logic [COL_BITS-1:0] x,
  input  logic [ROW_BITS-1:0] y,
  output logic [COL_BITS-1:0] new_x,
  output logic [ROW_BITS-1:0] new_y,
  output logic                wen,
  output logic [7:0]          char_out,
  output logic                char_wen,
  output logic                scroll
);

  typedef enum logic [1:0] {IDLE, ESC, ADDR_ROW, ADDR_COL} state_t;

  localparam logic [7:0] COL_MAX = 8'(COLS - 1);
  localparam logic [7:0] ROW_MAX = 8'(ROWS - 1);
  localparam logic [7:0] COLS8   = 8'(COLS);
  localparam logic [7:0] ROWS8   = 8'(ROWS);

  state_t              state_q, state_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] new_x_d;
  logic [ROW_BITS-1:0] new_y_d;
  logic [7:0]          char_out_d;
  logic                wen_d, char_wen_d, scroll_d;

  logic       accept;
  logic [7:0] x8, y8, d_off, tab8;

  // Cursor math is done at byte width and only truncated when stored.
  assign accept = valid & ready;
  assign x8     = 8'(x);
  assign y8     = 8'(y);
  assign d_off  = data - 8'h20;
  assign tab8   = (x8 | 8'h07) + 8'h01;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    new_x_d    = new_x;
    new_y_d    = new_y;
    char_out_d = char_out;
    wen_d      = 1'b0;
    char_wen_d = 1'b0;
    scroll_d   = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (data >= 8'h20 && data <= 8'h7e) begin
            char_wen_d = 1'b1;
            char_out_d = data;
            if (x8 < COL_MAX) begin
              wen_d   = 1'b1;
              new_x_d = COL_BITS'(x8 + 8'd1);
              new_y_d = y;
            end
          end else begin
            case (data)
              8'h0d: begin
                wen_d   = 1'b1;
                new_x_d = '0;
                new_y_d = y;
              end
              8'h0a: begin
                if (y8 < ROW_MAX) begin
                  wen_d   = 1'b1;
                  new_x_d = x;
                  new_y_d = ROW_BITS'(y8 + 8'd1);
                end else begin
                  scroll_d = 1'b1;
                end
              end
              8'h08: begin
                if (x8 != 8'd0) begin
                  wen_d   = 1'b1;
                  new_x_d = COL_BITS'(x8 - 8'd1);
                  new_y_d = y;
                end
              end
              8'h09: begin
                if (x8 < COL_MAX) begin
                  wen_d   = 1'b1;
                  new_x_d = COL_BITS'((tab8 > COL_MAX) ? COL_MAX : tab8);
                  new_y_d = y;
                end
              end
              8'h1b:   state_d = ESC;
              default: ;
            endcase
          end
        end
        ESC: begin
          state_d = IDLE;
          case (data)
            8'h41: if (y8 != 8'd0) begin
              wen_d = 1'b1; new_x_d = x; new_y_d = ROW_BITS'(y8 - 8'd1);
            end
            8'h42: if (y8 < ROW_MAX) begin
              wen_d = 1'b1; new_x_d = x; new_y_d = ROW_BITS'(y8 + 8'd1);
            end
            8'h43: if (x8 < COL_MAX) begin
              wen_d = 1'b1; new_x_d = COL_BITS'(x8 + 8'd1); new_y_d = y;
            end
            8'h44: if (x8 != 8'd0) begin
              wen_d = 1'b1; new_x_d = COL_BITS'(x8 - 8'd1); new_y_d = y;
            end
            8'h48: begin
              wen_d = 1'b1; new_x_d = '0; new_y_d = '0;
            end
            8'h59:   state_d = ADDR_ROW;
            8'h1b:   state_d = ESC;
            default: ;
          endcase
        end
        // Address bytes are raw data: an ESC here is a coordinate, not a restart.
        ADDR_ROW: begin
          row_d   = (data < 8'h20 || d_off >= ROWS8) ? y : ROW_BITS'(d_off);
          state_d = ADDR_COL;
        end
        ADDR_COL: begin
          wen_d   = 1'b1;
          new_x_d = (data < 8'h20 || d_off >= COLS8) ? x : COL_BITS'(d_off);
          new_y_d = row_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      row_q    <= '0;
      new_x    <= '0;
      new_y    <= '0;
      char_out <= '0;
      wen      <= 1'b0;
      char_wen <= 1'b0;
      scroll   <= 1'b0;
      ready    <= 1'b1;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      new_x    <= new_x_d;
      new_y    <= new_y_d;
      char_out <= char_out_d;
      wen      <= wen_d;
      char_wen <= char_wen_d;
      scroll   <= scroll_d;
      ready    <= !(wen_d | char_wen_d | scroll_d);
    end
  end

endmodule

// File: doc/cursor_motion.md
CURSOR_MOTION -- requirements
Module: cursor_motion

Interface
REQ-001 SHALL have parameter ROW_BITS, default 5, row index width.
REQ-002 SHALL have parameter COL_BITS, default 7, column index width.
REQ-003 SHALL have parameter ROWS, default 24, number of screen rows.
REQ-004 SHALL have parameter COLS, default 80, number of screen columns.
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port data  input  8  incoming terminal byte.
REQ-008 SHALL have port valid  input  1  data is valid.
REQ-009 SHALL have port ready  output  1  a byte is accepted when valid and ready are both 1.
REQ-010 SHALL have port x  input  COL_BITS  current cursor column.
REQ-011 SHALL have port y  input  ROW_BITS  current cursor row.
REQ-012 SHALL have port new_x  output  COL_BITS  requested cursor column.
REQ-013 SHALL have port new_y  output  ROW_BITS  requested cursor row.
REQ-014 SHALL have port wen  output  1  cursor position write strobe, 1 cycle.
REQ-015 SHALL have port char_out  output  8  printable byte to store.
REQ-016 SHALL have port char_wen  output  1  character write strobe at (x,y) of acceptance, 1 cycle.
REQ-017 SHALL have port scroll  output  1  scroll-up request, 1-cycle pulse.

Function
REQ-018 SHALL register all outputs; every effect of a byte accepted in cycle N SHALL appear in cycle N+1 only.
REQ-019 SHALL drive ready=0 in every cycle where wen, char_wen or scroll is 1, and ready=1 otherwise.
REQ-020 SHALL use FSM states IDLE, ESC, ADDR_ROW, ADDR_COL; unaccepted cycles SHALL leave state unchanged.
REQ-021 IDLE, 0x20-0x7E: char_wen=1, char_out=data; if x<COLS-1 then wen=1, new_x=x+1, new_y=y; at x=COLS-1, no wen.
REQ-022 IDLE, 0x0D (CR): wen=1, new_x=0, new_y=y.
REQ-023 IDLE, 0x0A (LF): y<ROWS-1 -> wen=1, new_y=y+1, new_x=x; y=ROWS-1 -> scroll=1, no wen.
REQ-024 IDLE, 0x08 (BS): x>0 -> wen=1, new_x=x-1; x=0 -> no output.
REQ-025 IDLE, 0x09 (TAB): x<COLS-1 -> wen=1, new_x=min((x|7)+1, COLS-1); x=COLS-1 -> no output.
REQ-026 IDLE, 0x1B -> ESC; all other bytes ignored, state stays IDLE.
REQ-027 ESC: 'A' up if y>0; 'B' down if y<ROWS-1 (never scroll); 'C' right if x<COLS-1; 'D' left if x>0; each with wen=1, other coordinate unchanged; next IDLE.
REQ-028 ESC: 'H' -> wen=1, new_x=0, new_y=0; 'Y' -> ADDR_ROW, no output; 0x1B -> stay ESC; any other byte -> IDLE, no output.
REQ-029 Moves at a boundary (REQ-027) SHALL produce no wen; state SHALL still return to IDLE.
REQ-030 ADDR_ROW: latch row=data-0x20; if data<0x20 or row>=ROWS, latch current y; next ADDR_COL, no output.
REQ-031 ADDR_COL: col=data-0x20, out of range (data<0x20 or col>=COLS) -> current x; wen=1 with new_x=col, new_y=latched row, always; next IDLE.
REQ-032 In ADDR_ROW/ADDR_COL, 0x1B SHALL be taken as an address byte, not a restart.
REQ-033 Arithmetic SHALL be done at 8 bits before truncation to COL_BITS/ROW_BITS.

Reset
REQ-034 While reset=0: state=IDLE, latched row=0, wen=char_wen=scroll=0, new_x=new_y=0, char_out=0, ready=1.
REQ-035 Reset asserted mid-sequence (ESC or ADDR_*) SHALL abandon it; no output pulse after release.

Verification
REQ-036 x=5,y=3, 'A'(0x41) -> next cycle char_wen=1, char_out=0x41, wen=1, new_x=6, new_y=3, ready=0; ready=1 a cycle later.
REQ-037 x=79,y=23: 'Z' -> char_wen=1, wen=0; LF -> scroll=1, wen=0; CR -> wen=1, new_x=0, new_y=23.
REQ-038 ESC,'Y',0x2A,0x35 -> single wen=1 with new_y=10, new_x=21; ESC,'Y',0x50,0x90 from (4,2) -> new_x=4, new_y=2.
REQ-039 x=0,y=0: ESC 'A', ESC 'D', BS -> no wen; ESC 'Q' then 'B' -> char_wen for 'B', state IDLE.
REQ-040 TAB from x=3 -> new_x=8; from x=77 -> new_x=79; from x=79 -> no wen.
REQ-041 Reset after ESC,'Y'; release; send 0x41 -> treated as printable (char_wen=1).
